// File: rtl/bt_cmd_decoder_if.sv
// Byte bus between the UART pair and the command decoder: RX byte strobe in, ack byte out.
// Latency: none, this is wiring only.
// Backpressure: only the ack direction has it (TX_VALID held until TX_READY); RX is a bare strobe.
interface bt_cmd_if;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       TX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_READY;

  // UART side: supplies received bytes and accepts ack bytes.
  modport master (
    output RX_VALID,
    output RX_DATA,
    output TX_READY,
    input  TX_VALID,
    input  TX_DATA
  );

  // Decoder side: consumes received bytes and offers ack bytes.
  modport slave (
    input  RX_VALID,
    input  RX_DATA,
    input  TX_READY,
    output TX_VALID,
    output TX_DATA
  );
endinterface

// File: rtl/bt_cmd_decoder.sv
// Bluetooth command decoder: UART bytes -> track/volume/play/mute control, plus an extended
// track-select frame. Latency: one cycle from RX_VALID to registered outputs and ack.
// Backpressure: none on RX; an ack arriving while the previous one is unaccepted is dropped and
// flagged on sticky ACK_OVR. The ack path exists only when ACK_EN is defined.
module bt_cmd_decoder #(
  parameter int NUM_TRACKS  = 7,
  parameter int VOL_W       = 4,
  parameter int VOL_MAX     = 15,
  parameter int VOL_INIT    = 8,
  parameter int ARG_TIMEOUT = 5000000,
  localparam int TRACK_W    = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  bt_cmd_if.slave            bus,
  output logic [TRACK_W-1:0] TRACK,
  output logic               TRACK_CHG,
  output logic [VOL_W-1:0]   VOL,
  output logic               VOL_CHG,
  output logic               PLAY,
  output logic               MUTE,
  output logic               ACK_OVR
);

  // Timer only has to count up to ARG_TIMEOUT-1.
  localparam int TMR_W = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;

  // Direct-select opcodes run from 0x05 up to 0x05+NUM_TRACKS-1, never past 0x0F.
  localparam int DIRECT_LAST = ((4 + NUM_TRACKS) > 15) ? 15 : (4 + NUM_TRACKS);

  localparam logic [7:0]         DIRECT_FIRST_B = 8'h05;
  localparam logic [7:0]         DIRECT_LAST_B  = 8'(DIRECT_LAST);
  localparam logic [7:0]         NUM_TRACKS_B   = 8'(NUM_TRACKS);
  localparam logic [TRACK_W-1:0] TRACK_LAST     = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [VOL_W-1:0]   VOL_MAX_V      = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0]   VOL_INIT_V     = VOL_W'(VOL_INIT);
  localparam logic [TMR_W-1:0]   TMR_LAST       = TMR_W'(ARG_TIMEOUT - 1);

  localparam logic [7:0] ACK_EXT = 8'hA0;
  localparam logic [7:0] ACK_NAK = 8'hEE;

  typedef enum logic {
    S_IDLE,
    S_WAIT_ARG
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [TRACK_W-1:0]   track_q, track_d;
  logic                 track_chg_q, track_chg_d;
  logic [VOL_W-1:0]     vol_q, vol_d;
  logic                 vol_chg_q, vol_chg_d;
  logic                 play_q, play_d;
  logic                 mute_q, mute_d;

  // Ack request produced by the decoder this cycle; consumed by the ack path below.
  logic                 ack_new;
  logic [7:0]           ack_byte;
  logic [7:0]           direct_idx;

  assign direct_idx = bus.RX_DATA - DIRECT_FIRST_B;

  // Decode: next state, control updates, change pulses and the ack byte for this command.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    track_d     = track_q;
    track_chg_d = 1'b0;
    vol_d       = vol_q;
    vol_chg_d   = 1'b0;
    play_d      = play_q;
    mute_d      = mute_q;
    ack_new     = 1'b0;
    ack_byte    = 8'h00;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.RX_VALID) begin
          ack_new  = 1'b1;
          ack_byte = 8'h80 | bus.RX_DATA;
          if ((bus.RX_DATA >= DIRECT_FIRST_B) && (bus.RX_DATA <= DIRECT_LAST_B)) begin
            track_d     = direct_idx[TRACK_W-1:0];
            track_chg_d = 1'b1;
          end else begin
            case (bus.RX_DATA)
              8'h01: begin
                track_d     = (track_q == '0) ? TRACK_LAST : track_q - TRACK_W'(1);
                track_chg_d = 1'b1;
              end
              8'h02: begin
                track_d     = (track_q == TRACK_LAST) ? '0 : track_q + TRACK_W'(1);
                track_chg_d = 1'b1;
              end
              8'h03: begin
                // Saturated: no change pulse, but the command is still acknowledged as ok.
                if (vol_q < VOL_MAX_V) begin
                  vol_d     = vol_q + VOL_W'(1);
                  vol_chg_d = 1'b1;
                end
              end
              8'h04: begin
                if (vol_q != '0) begin
                  vol_d     = vol_q - VOL_W'(1);
                  vol_chg_d = 1'b1;
                end
              end
              8'h10: play_d = ~play_q;
              8'h11: mute_d = ~mute_q;
              8'h20: begin
                // Ack is deferred until the argument byte arrives or the wait times out.
                state_d = S_WAIT_ARG;
                timer_d = '0;
                ack_new = 1'b0;
              end
              default: ack_byte = ACK_NAK;
            endcase
          end
        end
      end

      S_WAIT_ARG: begin
        if (bus.RX_VALID) begin
          // The argument byte is never reinterpreted as an opcode, even when out of range.
          state_d = S_IDLE;
          timer_d = '0;
          ack_new = 1'b1;
          if (bus.RX_DATA < NUM_TRACKS_B) begin
            track_d     = bus.RX_DATA[TRACK_W-1:0];
            track_chg_d = 1'b1;
            ack_byte    = ACK_EXT;
          end else begin
            ack_byte    = ACK_NAK;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          ack_new  = 1'b1;
          ack_byte = ACK_NAK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Decoder state and control registers; reset also abandons any half-received extended frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      track_q     <= '0;
      track_chg_q <= 1'b0;
      vol_q       <= VOL_INIT_V;
      vol_chg_q   <= 1'b0;
      play_q      <= 1'b0;
      mute_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      track_q     <= track_d;
      track_chg_q <= track_chg_d;
      vol_q       <= vol_d;
      vol_chg_q   <= vol_chg_d;
      play_q      <= play_d;
      mute_q      <= mute_d;
    end
  end

  assign TRACK     = track_q;
  assign TRACK_CHG = track_chg_q;
  assign VOL       = vol_q;
  assign VOL_CHG   = vol_chg_q;
  assign PLAY      = play_q;
  assign MUTE      = mute_q;

`ifdef ACK_EN
  logic       tx_vld_q, tx_vld_d;
  logic [7:0] tx_dat_q, tx_dat_d;
  logic       ack_ovr_q, ack_ovr_d;

  // Single-entry ack holding register: a new ack loads only if the slot is free or being
  // accepted this cycle; otherwise the old byte wins and the drop is recorded.
  always_comb begin
    tx_vld_d  = tx_vld_q;
    tx_dat_d  = tx_dat_q;
    ack_ovr_d = ack_ovr_q;
    if (ack_new) begin
      if (!tx_vld_q || bus.TX_READY) begin
        tx_vld_d = 1'b1;
        tx_dat_d = ack_byte;
      end else begin
        ack_ovr_d = 1'b1;
      end
    end else if (tx_vld_q && bus.TX_READY) begin
      tx_vld_d = 1'b0;
    end
  end

  // Ack registers; ACK_OVR stays set until reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_vld_q  <= 1'b0;
      tx_dat_q  <= 8'h00;
      ack_ovr_q <= 1'b0;
    end else begin
      tx_vld_q  <= tx_vld_d;
      tx_dat_q  <= tx_dat_d;
      ack_ovr_q <= ack_ovr_d;
    end
  end

  assign bus.TX_VALID = tx_vld_q;
  assign bus.TX_DATA  = tx_dat_q;
  assign ACK_OVR      = ack_ovr_q;
`else
  // No ack path: outputs held low and the ack request is simply discarded.
  logic unused_ack;
  assign unused_ack   = &{1'b0, bus.TX_READY, ack_new, ack_byte};
  assign bus.TX_VALID = 1'b0;
  assign bus.TX_DATA  = 8'h00;
  assign ACK_OVR      = 1'b0;
`endif

endmodule

// File: doc/bt_cmd_decoder.md
Name: bt_cmd_decoder

Overview:
Parametrised, fully synchronous successor to the Bluetooth command decoder. Consumes bytes already deframed by the UART receiver (one-cycle valid strobe) and drives the player's control state: track select with wrap, saturating volume, play/pause and mute. Adds a two-byte extended track-select frame with an inter-byte timeout, and an optional acknowledge byte handed to the UART transmitter. Sits between UartReciever/UartReply and the MP3 playback core.

Parameters:
NUM_TRACKS, 7, number of selectable tracks (2..64); TRACK_W = max(1, clog2(NUM_TRACKS)).
VOL_W, 4, volume width.
VOL_MAX, 15, upper volume limit (≤ 2^VOL_W-1).
VOL_INIT, 8, volume after reset.
ARG_TIMEOUT, 5000000, CLK cycles allowed between extended opcode and its argument byte.

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
RX_VALID  in  1  one-cycle strobe, RX_DATA valid
RX_DATA  in  8  received byte
TRACK  out  TRACK_W  current track index
TRACK_CHG  out  1  one-cycle pulse when TRACK is written (even if value unchanged)
VOL  out  VOL_W  current volume
VOL_CHG  out  1  one-cycle pulse when VOL value changes
PLAY  out  1  1 = playing
MUTE  out  1  1 = muted
TX_VALID  out  1  ack byte pending
TX_DATA  out  8  ack byte
TX_READY  in  1  transmitter accepts byte when TX_VALID & TX_READY
ACK_OVR  out  1  sticky: an ack was dropped

Behaviour:
- Reset (RST=0, async): TRACK=0, VOL=VOL_INIT, PLAY=0, MUTE=0, all pulses 0, TX_VALID=0, TX_DATA=0, ACK_OVR=0, FSM=IDLE, timer=0. Reset mid-frame discards the pending argument.
- Latency: RX_VALID in cycle n -> state outputs, pulses and TX_VALID registered at n+1. RX_DATA sampled only when RX_VALID=1.
- FSM states: IDLE, WAIT_ARG.
- IDLE opcodes:
  0x01 prev: TRACK = (TRACK==0) ? NUM_TRACKS-1 : TRACK-1.
  0x02 next: TRACK = (TRACK==NUM_TRACKS-1) ? 0 : TRACK+1.
  0x03 vol up: VOL+1, saturate at VOL_MAX (no VOL_CHG at limit; still ACK ok).
  0x04 vol down: VOL-1, saturate at 0.
  0x05..0x05+NUM_TRACKS-1 (capped at 0x0F): TRACK = opcode-0x05.
  0x10: toggle PLAY. 0x11: toggle MUTE.
  0x20: go WAIT_ARG, clear timer; no ack yet.
  Any other byte: no state change, NAK.
- WAIT_ARG: timer increments each cycle. RX_VALID with byte < NUM_TRACKS -> TRACK=byte, TRACK_CHG, ok ack, IDLE. Byte >= NUM_TRACKS -> NAK, TRACK unchanged, IDLE (byte not reinterpreted as opcode). Timer reaching ARG_TIMEOUT-1 without byte -> IDLE, NAK issued.
- Ack bytes: ok = 0x80 | opcode (extended frame acks 0xA0); NAK = 0xEE.
- TX handshake: TX_VALID/TX_DATA held stable until TX_VALID & TX_READY, then TX_VALID=0 next cycle. New ack generated while TX_VALID=1 and not accepted that cycle: command still executed, new ack dropped, old byte kept, ACK_OVR set. Accept and new ack same cycle: new ack loaded, TX_VALID stays 1.
- TRACK_CHG/VOL_CHG never assert for longer than one cycle per command.

Optional Feature:
ACK_EN: defined -> acknowledge path as above. Undefined -> TX_VALID, TX_DATA, ACK_OVR tied 0, TX_READY ignored, no ack registers synthesised; decode behaviour otherwise identical.

Test Plan:
- Reset, then 0x01 -> TRACK=6 (NUM_TRACKS=7) at n+1, TRACK_CHG one cycle; 0x02 -> TRACK=0.
- Eight 0x03 from VOL=8 -> VOL=15, VOL_CHG on first 7 only; then 0x04 x16 -> VOL=0, no further change.
- 0x20 then 0x04 -> TRACK=4, TX_DATA=0xA0; 0x20 then 0x09 -> NAK 0xEE, TRACK unchanged; 0x20 with no byte for ARG_TIMEOUT (set to 16) cycles -> IDLE, 0xEE.
- TX_READY=0, send 0x10 then 0x11 -> PLAY=1, MUTE=1, TX_DATA stays 0x90, ACK_OVR=1; raise TX_READY -> TX_VALID drops next cycle.
- Send 0x20, assert RST mid-wait, release, send 0x03 -> treated as vol-up (VOL=9), not as argument.
- Unknown 0x55 -> no output change, TX_DATA=0xEE; with ACK_EN undefined, TX_VALID never asserts.
